rom_fetcher: RTL and testbench
==============================

ROM_FETCHER -- requirements
Module: rom_fetcher

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high, ports named clock and reset.
REQ-002 SHALL have ports, listed as name  direction  width  meaning:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  async active-high reset
- halt  in  1  freeze phase sequencing and all state
- data_i  in  4  shared bus value from external mux
- data_o  out  4  nibble driven by this block
- data_en  out  1  data_o valid on bus
- sync  out  1  instruction-cycle marker, high in phase X3
- rom_cmd  out  1  ROM command strobe, high in A3 of an active cycle
- req_valid  in  1  fetch request pending
- req_addr  in  12  ROM address, [11:8] chip id, [7:0] byte
- req_ready  out  1  request accepted this clock
- rsp_valid  out  1  one-clock pulse, fetched byte valid
- rsp_data  out  8  fetched byte {OPR,OPA}

Function
REQ-003 SHALL sequence a free-running 8-phase cycle A1,A2,A3,M1,M2,X1,X2,X3, advancing one phase per clock when halt=0 and wrapping from X3 to A1.
REQ-004 SHALL assert sync exactly when phase=X3.
REQ-005 SHALL assert req_ready only when phase=X3, halt=0 and req_valid=1; the following cycle is then active and req_addr is latched.
REQ-006 SHALL treat a cycle as idle when no request is accepted at the preceding X3; an idle cycle has data_en=0, rom_cmd=0 and rsp_valid=0 in all phases.
REQ-007 SHALL, in an active cycle, drive data_o=addr[3:0] in A1, addr[7:4] in A2, addr[11:8] in A3, with data_en=1 in A1-A3 only.
REQ-008 SHALL assert rom_cmd in A3 of an active cycle only.
REQ-009 SHALL capture data_i as OPR at the end of M1 and as OPA at the end of M2 of an active cycle.
REQ-010 SHALL pulse rsp_valid for one clock in X1 of an active cycle with rsp_data={OPR,OPA}; rsp_data holds until the next capture.
REQ-011 SHALL have a fixed latency of 6 clocks from the req_ready clock to the rsp_valid clock when halt stays 0; responses have no backpressure.
REQ-012 SHALL support back-to-back requests: one accepted every 8 clocks, responses in order.
REQ-013 SHALL ignore req_valid outside X3; a request withdrawn before X3 is never issued.
REQ-014 SHALL, while halt=1, hold phase, all outputs and latched state, force req_ready=0, and not sample data_i; a multi-clock halt stretches latency by its length.
REQ-015 SHALL never assert data_en in M1-X3, avoiding contention with ROM/RAM responders.

Reset
REQ-016 SHALL on reset force phase=X3 and cycle=idle, with latched address, OPR and OPA cleared to 0.
REQ-017 SHALL hold the following values during reset: sync=1, data_en=0, data_o=0, rom_cmd=0, req_ready=0, rsp_valid=0, rsp_data=0.
REQ-018 SHALL abort a cycle interrupted by reset with no rsp_valid; the first req_ready is possible in the first clock after deassertion.

Structure
REQ-019 SHALL take phase encodings (A1=0 ... X3=7) and the bus width constant from the shared bus package.
REQ-020 SHALL contain one sub-module, cycle_timer, holding the phase counter with halt; it outputs phase and sync.

Verification
REQ-021 Single fetch: ROM chip 0 holds 0xD5 at byte 0x12; req_addr=0x012 at X3 -> data_o 2,1,0 in A1-A3, rom_cmd in A3, rsp_valid 6 clocks later with rsp_data=0xD5.
REQ-022 Back-to-back: requests 0x100 then 0x101 held valid -> req_ready 8 clocks apart, two rsp_valid pulses 8 clocks apart, in order.
REQ-023 Idle: req_valid=0 for 3 cycles -> sync every 8 clocks, data_en, rom_cmd and rsp_valid stay 0.
REQ-024 Halt: halt=1 for 5 clocks during M1 of an active fetch -> outputs frozen, rsp_valid after 11 clocks, correct byte.
REQ-025 Reset mid-cycle: reset asserted in M2 -> no rsp_valid, sync=1 immediately, next request accepted on the first clock after release.
REQ-026 Late request: req_valid raised in A2 and held -> req_ready only at the next X3.

Source files
------------

// File: rtl/rom_fetcher_pkg.sv
// Shared bus definitions for the ROM fetcher: nibble bus width, address layout
// and the eight-phase instruction cycle encoding.
package rom_fetcher_pkg;

    localparam int BUS_W   = 4;
    localparam int ADDR_W  = 12;
    localparam int BYTE_W  = 2 * BUS_W;
    localparam int NIBBLES = ADDR_W / BUS_W;

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_t;

    // Only the address phases may drive the shared bus; responders own M1-X3.
    function automatic logic drives_bus(input phase_t ph);
        return (ph == PH_A1) || (ph == PH_A2) || (ph == PH_A3);
    endfunction

endpackage

// File: rtl/rom_fetcher_cycle_timer.sv
// Free-running eight-phase cycle counter; halt freezes it, reset parks it in X3.
module cycle_timer
    import rom_fetcher_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   halt,
    output phase_t phase,
    output logic   sync
);

    phase_t phase_reg;
    phase_t phase_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_reg <= PH_X3;
        end else begin
            phase_reg <= phase_next;
        end
    end

    always_comb begin
        phase_next = phase_reg;
        if (!halt) begin
            if (phase_reg == PH_X3) begin
                phase_next = PH_A1;
            end else begin
                phase_next = phase_t'(phase_reg + 3'd1);
            end
        end
    end

    assign phase = phase_reg;
    assign sync  = (phase_reg == PH_X3);

endmodule

// File: rtl/rom_fetcher.sv
// Nibble-serial ROM fetch engine: sends a 12-bit address in A1-A3, collects the
// returned byte in M1/M2 and reports it in X1 of the same instruction cycle.
module rom_fetcher
    import rom_fetcher_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              halt,
    input  logic [BUS_W-1:0]  data_i,
    output logic [BUS_W-1:0]  data_o,
    output logic              data_en,
    output logic              sync,
    output logic              rom_cmd,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [BYTE_W-1:0] rsp_data
);

    phase_t              phase;
    logic                active_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [BUS_W-1:0]    opr_reg;
    logic [BYTE_W-1:0]   rsp_data_reg;
    logic [BUS_W-1:0]    addr_nib [4];

    cycle_timer u_cycle_timer (
        .clock (clock),
        .reset (reset),
        .halt  (halt),
        .phase (phase),
        .sync  (sync)
    );

    // Nibble lookup indexed directly by phase[1:0] during A1-A3; slot 3 is never driven out.
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
        if (gi < NIBBLES) begin : g_used
            assign addr_nib[gi] = addr_reg[gi*BUS_W +: BUS_W];
        end else begin : g_pad
            assign addr_nib[gi] = '0;
        end
    end

    // The active flag is decided only at X3, so it covers exactly the following cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_reg   <= 1'b0;
            addr_reg     <= '0;
            opr_reg      <= '0;
            rsp_data_reg <= '0;
        end else if (!halt) begin
            if (phase == PH_X3) begin
                active_reg <= req_valid;
                if (req_valid) begin
                    addr_reg <= req_addr;
                end
            end
            if (active_reg && (phase == PH_M1)) begin
                opr_reg <= data_i;
            end
            if (active_reg && (phase == PH_M2)) begin
                rsp_data_reg <= {opr_reg, data_i};
            end
        end
    end

    always_comb begin
        data_en   = active_reg && drives_bus(phase);
        data_o    = '0;
        if (data_en) begin
            data_o = addr_nib[phase[1:0]];
        end
        rom_cmd   = active_reg && (phase == PH_A3);
        rsp_valid = active_reg && (phase == PH_X1);
        req_ready = (phase == PH_X3) && !halt && req_valid && !reset;
    end

    assign rsp_data = rsp_data_reg;

endmodule

// File: tb/tb_rom_fetcher.sv
// Self-checking bench for rom_fetcher: a phase-level reference model plus ROM
// image drives data_i and predicts every output each clock.
module tb_rom_fetcher;

    logic        clock = 1'b0;
    logic        reset;
    logic        halt;
    logic [3:0]  data_i;
    logic [3:0]  data_o;
    logic        data_en;
    logic        sync;
    logic        rom_cmd;
    logic        req_valid;
    logic [11:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;

    rom_fetcher dut (
        .clock     (clock),
        .reset     (reset),
        .halt      (halt),
        .data_i    (data_i),
        .data_o    (data_o),
        .data_en   (data_en),
        .sync      (sync),
        .rom_cmd   (rom_cmd),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]  rom [4096];

    // Reference model: phase index 0..7 = A1..X3, whether this cycle fetches, and the last byte.
    int          m_ph;
    bit          m_act;
    logic [11:0] m_addr;
    logic [7:0]  m_rsp;

    logic        o_sync, o_en, o_cmd, o_rdy, o_rv;
    logic [3:0]  o_do;
    logic [7:0]  o_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit h, input bit v, input logic [11:0] a);
        logic [11:0] sh;
        bit          e_en;
        @(negedge clock);
        cyc++;
        reset     = r;
        halt      = h;
        req_valid = v;
        req_addr  = a;
        if (r) begin
            m_ph = 7; m_act = 0; m_addr = '0; m_rsp = '0;
        end
        // The ROM answers only on the clock that actually samples; anything else is noise.
        if (!r && !h && m_act && m_ph == 3)      data_i = rom[m_addr][7:4];
        else if (!r && !h && m_act && m_ph == 4) data_i = rom[m_addr][3:0];
        else                                     data_i = 4'($urandom);
        #1;
        o_sync = sync; o_en = data_en; o_cmd = rom_cmd; o_rdy = req_ready;
        o_rv = rsp_valid; o_do = data_o; o_rd = rsp_data;
        e_en = m_act && (m_ph < 3);
        sh   = m_addr >> (m_ph * 4);
        chk("sync",      32'(o_sync), 32'(m_ph == 7));
        chk("req_ready", 32'(o_rdy),  32'(m_ph == 7 && !h && v && !r));
        chk("data_en",   32'(o_en),   32'(e_en));
        chk("data_o",    32'(o_do),   e_en ? 32'(sh[3:0]) : 32'd0);
        chk("rom_cmd",   32'(o_cmd),  32'(m_act && m_ph == 2));
        chk("rsp_valid", 32'(o_rv),   32'(m_act && m_ph == 5));
        chk("rsp_data",  32'(o_rd),   32'(m_rsp));
        @(posedge clock);
        if (!r && !h) begin
            if (m_ph == 7) begin
                m_act = v;
                if (v) m_addr = a;
            end
            if (m_act && m_ph == 4) m_rsp = rom[m_addr];
            m_ph = (m_ph + 1) % 8;
        end
    endtask

    task automatic run_to_x3();
        for (int i = 0; i < 8 && m_ph != 7; i++) step(0, 0, 0, 12'h000);
    endtask

    initial begin
        logic [3:0]  exp_nib [3];
        int          t0, cnt, acc, nr;
        int          t_rdy [2];
        int          t_rsp [2];
        logic [7:0]  d_rsp [2];
        logic [11:0] ha;

        reset = 1'b1; halt = 1'b0; req_valid = 1'b0; req_addr = '0; data_i = '0;
        m_ph = 7; m_act = 0; m_addr = '0; m_rsp = '0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[12'h012] = 8'hD5;
        exp_nib[0] = 4'h2; exp_nib[1] = 4'h1; exp_nib[2] = 4'h0;

        // Reset values, with a request presented that must not be accepted.
        step(1, 0, 1, 12'h012);
        chk("rst_sync", 32'(o_sync), 32'd1);
        chk("rst_ready", 32'(o_rdy), 32'd0);
        chk("rst_rsp_data", 32'(o_rd), 32'd0);
        chk("rst_data_en", 32'(o_en), 32'd0);

        // Single fetch of 0x012 -> 0xD5.
        step(0, 0, 1, 12'h012);
        chk("single_ready", 32'(o_rdy), 32'd1);
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 12'h000);
            chk("single_nibble", 32'(o_do), 32'(exp_nib[i]));
            chk("single_cmd", 32'(o_cmd), 32'(i == 2));
        end
        step(0, 0, 0, 12'h000);
        step(0, 0, 0, 12'h000);
        step(0, 0, 0, 12'h000);
        chk("single_latency", 32'(o_rv ? cyc - t0 : -1), 32'd6);
        chk("single_byte", 32'(o_rd), 32'hD5);

        // Back-to-back requests 0x100, 0x101.
        run_to_x3();
        acc = 0; nr = 0;
        t_rdy[0] = 0; t_rdy[1] = 0; t_rsp[0] = 0; t_rsp[1] = 0; d_rsp[0] = '0; d_rsp[1] = '0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, acc < 2, acc == 0 ? 12'h100 : 12'h101);
            if (o_rdy && acc < 2) begin t_rdy[acc] = cyc; acc++; end
            if (o_rv && nr < 2) begin t_rsp[nr] = cyc; d_rsp[nr] = o_rd; nr++; end
        end
        chk("b2b_count", 32'(nr), 32'd2);
        chk("b2b_ready_gap", 32'(t_rdy[1] - t_rdy[0]), 32'd8);
        chk("b2b_rsp_gap", 32'(t_rsp[1] - t_rsp[0]), 32'd8);
        chk("b2b_first", 32'(d_rsp[0]), 32'(rom[12'h100]));
        chk("b2b_second", 32'(d_rsp[1]), 32'(rom[12'h101]));

        // Idle for three cycles.
        run_to_x3();
        cnt = 0; acc = 0;
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 0, 12'h000);
            cnt += int'(o_sync);
            acc += int'(o_en) + int'(o_cmd) + int'(o_rv);
        end
        chk("idle_sync", 32'(cnt), 32'd3);
        chk("idle_quiet", 32'(acc), 32'd0);

        // Five-clock halt in M1 stretches latency to 11.
        run_to_x3();
        ha = 12'(($urandom % 4095) + 1);
        step(0, 0, 1, ha);
        t0 = cyc;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 12'h000);
        for (int i = 0; i < 5; i++) step(0, 1, i % 2 == 0, ha);
        for (int i = 0; i < 6 && !o_rv; i++) step(0, 0, 0, 12'h000);
        chk("halt_latency", 32'(o_rv ? cyc - t0 : -1), 32'd11);
        chk("halt_byte", 32'(o_rd), 32'(rom[ha]));

        // Reset in M2 aborts the fetch.
        run_to_x3();
        step(0, 0, 1, 12'h3A5);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 12'h000);
        step(1, 0, 0, 12'h000);
        chk("mid_rst_sync", 32'(o_sync), 32'd1);
        chk("mid_rst_rsp", 32'(o_rv), 32'd0);
        step(1, 0, 1, 12'h2C7);
        step(0, 0, 1, 12'h2C7);
        chk("post_rst_ready", 32'(o_rdy), 32'd1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 12'h000);
            cnt += int'(o_rv);
        end
        chk("post_rst_no_rsp", 32'(cnt), 32'd0);
        step(0, 0, 0, 12'h000);
        chk("post_rst_rsp", 32'(o_rv), 32'd1);
        chk("post_rst_byte", 32'(o_rd), 32'(rom[12'h2C7]));

        // Request raised in A2 waits for the next X3.
        run_to_x3();
        step(0, 0, 0, 12'h000);
        step(0, 0, 0, 12'h000);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 12'h055);
            cnt += int'(o_rdy);
        end
        chk("late_early_ready", 32'(cnt), 32'd0);
        step(0, 0, 1, 12'h055);
        chk("late_ready_x3", 32'(o_rdy), 32'd1);

        // Randomized traffic with occasional halts and resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom % 200 == 0, $urandom % 10 == 0, $urandom % 10 < 7, 12'($urandom));
        end
        step(0, 0, 0, 12'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
